// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for the interrupt controller: FSM states, IRQ codes,
// source indices and the fixed-priority selector.
package interrupt_controller_pkg;

  localparam int NUM_SRC   = 3;
  localparam int SRC_KBD   = 0;
  localparam int SRC_GPU   = 1;
  localparam int SRC_TIMER = 2;

  localparam logic [1:0] IRQ_NONE  = 2'd0;
  localparam logic [1:0] IRQ_KBD   = 2'd1;
  localparam logic [1:0] IRQ_GPU   = 2'd2;
  localparam logic [1:0] IRQ_TIMER = 2'd3;

  typedef enum logic [1:0] {
    IST_IDLE    = 2'd0,
    IST_REQUEST = 2'd1,
    IST_SERVICE = 2'd2
  } ist_state_t;

  // Lowest index wins; only meaningful when elig is non-zero.
  function automatic logic [1:0] prio_sel(input logic [NUM_SRC-1:0] elig);
    if (elig[SRC_KBD])      return 2'(SRC_KBD);
    else if (elig[SRC_GPU]) return 2'(SRC_GPU);
    else                    return 2'(SRC_TIMER);
  endfunction

endpackage

// File: rtl/interrupt_timer.sv
// Free-running periodic tick source: counts 0..TIMER_PERIOD-1 while enabled,
// holds while disabled, and pulses tick on the last count.
module interrupt_timer #(
  parameter int TIMER_PERIOD = 50000
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic TIMER_EN,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(TIMER_PERIOD - 1);

  logic [15:0] count;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)      count <= '0;
    else if (TIMER_EN) count <= (count == LAST) ? 16'd0 : count + 16'd1;
  end

  assign tick = TIMER_EN && (count == LAST);

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt responder: edge-latches keyboard/GPU/timer events, presents the
// highest-priority eligible one on INT_IRQ and serializes IACK/IEND service.
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int TIMER_PERIOD = 50000
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [1:0] SRC_IN,
  input  logic       TIMER_EN,
  input  logic [2:0] INT_MASK,
  input  logic       INT_IACK,
  input  logic       INT_IEND,
  input  logic       ERR_CLR,
  output logic [1:0] INT_IRQ,
  output logic [2:0] PENDING,
  output logic       BUSY,
  output logic       PROTO_ERR
);

  logic               tick;
  logic [NUM_SRC-1:0] src_cur, src_q, src_edge, clr, pending, eligible;
  logic [1:0]         id;
  logic               err;
  ist_state_t         state;

  interrupt_timer #(.TIMER_PERIOD(TIMER_PERIOD)) u_timer (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .TIMER_EN(TIMER_EN),
    .tick    (tick)
  );

  assign src_cur  = {tick, SRC_IN};
  assign src_edge = src_cur & ~src_q;
  assign eligible = pending & INT_MASK;

  always_comb begin
    clr = '0;
    if (state == IST_REQUEST && INT_IACK) clr[id] = 1'b1;
  end

  // Set after clear so a fresh edge on the bit being acknowledged survives.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      src_q   <= '0;
      pending <= '0;
    end else begin
      src_q   <= src_cur;
      pending <= (pending & ~clr) | src_edge;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= IST_IDLE;
      id      <= 2'd0;
      INT_IRQ <= IRQ_NONE;
    end else begin
      case (state)
        IST_IDLE: begin
          INT_IRQ <= IRQ_NONE;
          if (eligible != '0) begin
            id      <= prio_sel(eligible);
            INT_IRQ <= prio_sel(eligible) + 2'd1;
            state   <= IST_REQUEST;
          end
        end
        // Code is frozen here: no preemption, no withdrawal on mask change.
        IST_REQUEST: begin
          if (INT_IACK) begin
            INT_IRQ <= IRQ_NONE;
            state   <= IST_SERVICE;
          end
        end
        IST_SERVICE: begin
          INT_IRQ <= IRQ_NONE;
          if (INT_IEND) state <= IST_IDLE;
        end
        default: begin
          INT_IRQ <= IRQ_NONE;
          state   <= IST_IDLE;
        end
      endcase
    end
  end

  assign err = (INT_IACK && state != IST_REQUEST) ||
               (INT_IEND && state != IST_SERVICE);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)     PROTO_ERR <= 1'b0;
    else if (err)     PROTO_ERR <= 1'b1;
    else if (ERR_CLR) PROTO_ERR <= 1'b0;
  end

  assign PENDING = pending;
  assign BUSY    = (state != IST_IDLE);

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: inputs change 1ns after a rising
// edge and outputs are sampled at that same point.
module tb_interrupt_controller;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic [1:0] SRC_IN;
  logic       TIMER_EN;
  logic [2:0] INT_MASK;
  logic       INT_IACK, INT_IEND, ERR_CLR;
  logic [1:0] INT_IRQ;
  logic [2:0] PENDING;
  logic       BUSY, PROTO_ERR;

  int checks = 0;
  int errors = 0;

  interrupt_controller #(.TIMER_PERIOD(4)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .SRC_IN(SRC_IN), .TIMER_EN(TIMER_EN),
    .INT_MASK(INT_MASK), .INT_IACK(INT_IACK), .INT_IEND(INT_IEND),
    .ERR_CLR(ERR_CLR), .INT_IRQ(INT_IRQ), .PENDING(PENDING), .BUSY(BUSY),
    .PROTO_ERR(PROTO_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic test_reset;
    RESET_N = 1'b0; SRC_IN = 2'b00; TIMER_EN = 1'b0; INT_MASK = 3'b111;
    INT_IACK = 1'b0; INT_IEND = 1'b0; ERR_CLR = 1'b0;
    #2;
    checks++; if (INT_IRQ !== 2'd0) begin errors++; $display("FAIL reset_irq got %0d want 0", INT_IRQ); end
    checks++; if (PENDING !== 3'b000) begin errors++; $display("FAIL reset_pending got %b want 000", PENDING); end
    checks++; if (BUSY !== 1'b0 || PROTO_ERR !== 1'b0) begin errors++; $display("FAIL reset_busy_err got %b%b want 00", BUSY, PROTO_ERR); end
    step(2);
    RESET_N = 1'b1;
    step(2);
    checks++; if (INT_IRQ !== 2'd0 || BUSY !== 1'b0) begin errors++; $display("FAIL post_reset_idle got irq %0d busy %b want 0 0", INT_IRQ, BUSY); end
  endtask

  task automatic test_single;
    SRC_IN = 2'b01;
    step(1);
    checks++; if (PENDING !== 3'b001 || INT_IRQ !== 2'd0) begin errors++; $display("FAIL single_pend got %b/%0d want 001/0", PENDING, INT_IRQ); end
    step(1);
    checks++; if (INT_IRQ !== 2'd1 || BUSY !== 1'b1) begin errors++; $display("FAIL single_irq got %0d/%b want 1/1", INT_IRQ, BUSY); end
    INT_IACK = 1'b1; SRC_IN = 2'b00;
    step(1);
    INT_IACK = 1'b0;
    checks++; if (INT_IRQ !== 2'd0 || PENDING[0] !== 1'b0 || BUSY !== 1'b1) begin errors++; $display("FAIL single_iack got irq %0d pend %b busy %b want 0 xx0 1", INT_IRQ, PENDING, BUSY); end
    INT_IEND = 1'b1;
    step(1);
    INT_IEND = 1'b0;
    checks++; if (BUSY !== 1'b0 || PROTO_ERR !== 1'b0) begin errors++; $display("FAIL single_iend got busy %b err %b want 0 0", BUSY, PROTO_ERR); end
  endtask

  task automatic test_simultaneous;
    SRC_IN = 2'b11;
    step(1);
    SRC_IN = 2'b00;
    step(1);
    checks++; if (INT_IRQ !== 2'd1 || PENDING !== 3'b011) begin errors++; $display("FAIL simul_first got %0d/%b want 1/011", INT_IRQ, PENDING); end
    INT_IACK = 1'b1; step(1); INT_IACK = 1'b0;
    checks++; if (PENDING !== 3'b010) begin errors++; $display("FAIL simul_clr got %b want 010", PENDING); end
    INT_IEND = 1'b1; step(1); INT_IEND = 1'b0;
    step(1);
    checks++; if (INT_IRQ !== 2'd2) begin errors++; $display("FAIL simul_second got %0d want 2", INT_IRQ); end
    INT_IACK = 1'b1; step(1); INT_IACK = 1'b0;
    INT_IEND = 1'b1; step(1); INT_IEND = 1'b0;
    checks++; if (BUSY !== 1'b0 || PENDING !== 3'b000) begin errors++; $display("FAIL simul_done got busy %b pend %b want 0 000", BUSY, PENDING); end
    step(1);
    checks++; if (INT_IRQ !== 2'd0) begin errors++; $display("FAIL simul_quiet got %0d want 0", INT_IRQ); end
  endtask

  task automatic test_no_preempt;
    SRC_IN = 2'b10; step(1); SRC_IN = 2'b00; step(1);
    checks++; if (INT_IRQ !== 2'd2) begin errors++; $display("FAIL nopre_gpu got %0d want 2", INT_IRQ); end
    SRC_IN = 2'b01; step(1); SRC_IN = 2'b00; step(1);
    checks++; if (INT_IRQ !== 2'd2 || PENDING !== 3'b011) begin errors++; $display("FAIL nopre_hold got %0d/%b want 2/011", INT_IRQ, PENDING); end
    INT_MASK = 3'b000; step(1);
    checks++; if (INT_IRQ !== 2'd2) begin errors++; $display("FAIL nopre_mask_hold got %0d want 2", INT_IRQ); end
    INT_MASK = 3'b111;
    INT_IACK = 1'b1; step(1); INT_IACK = 1'b0;
    checks++; if (INT_IRQ !== 2'd0 || PENDING !== 3'b001) begin errors++; $display("FAIL nopre_iack got %0d/%b want 0/001", INT_IRQ, PENDING); end
    INT_IEND = 1'b1; step(1); INT_IEND = 1'b0;
    step(1);
    checks++; if (INT_IRQ !== 2'd1) begin errors++; $display("FAIL nopre_next got %0d want 1", INT_IRQ); end
    INT_IACK = 1'b1; step(1); INT_IACK = 1'b0;
    INT_IEND = 1'b1; step(1); INT_IEND = 1'b0;
  endtask

  task automatic test_mask;
    INT_MASK = 3'b110;
    SRC_IN = 2'b01; step(1); SRC_IN = 2'b00; step(3);
    checks++; if (PENDING !== 3'b001 || INT_IRQ !== 2'd0 || BUSY !== 1'b0) begin errors++; $display("FAIL mask_block got %b/%0d/%b want 001/0/0", PENDING, INT_IRQ, BUSY); end
    INT_MASK = 3'b111; step(1);
    checks++; if (INT_IRQ !== 2'd1) begin errors++; $display("FAIL mask_release got %0d want 1", INT_IRQ); end
    INT_IACK = 1'b1; step(1); INT_IACK = 1'b0;
    INT_IEND = 1'b1; step(1); INT_IEND = 1'b0;
  endtask

  task automatic test_timer;
    TIMER_EN = 1'b1;
    step(3);
    checks++; if (PENDING !== 3'b000) begin errors++; $display("FAIL timer_early got %b want 000", PENDING); end
    step(1);
    checks++; if (PENDING !== 3'b100 || INT_IRQ !== 2'd0) begin errors++; $display("FAIL timer_tick got %b/%0d want 100/0", PENDING, INT_IRQ); end
    step(1);
    checks++; if (INT_IRQ !== 2'd3) begin errors++; $display("FAIL timer_irq got %0d want 3", INT_IRQ); end
    INT_IACK = 1'b1; step(1); INT_IACK = 1'b0;
    checks++; if (PENDING !== 3'b000 || INT_IRQ !== 2'd0) begin errors++; $display("FAIL timer_iack got %b/%0d want 000/0", PENDING, INT_IRQ); end
    step(1);
    checks++; if (PENDING !== 3'b000) begin errors++; $display("FAIL timer_gap got %b want 000", PENDING); end
    step(1);
    checks++; if (PENDING !== 3'b100) begin errors++; $display("FAIL timer_period got %b want 100", PENDING); end
    step(9);
    checks++; if (PENDING !== 3'b100 || BUSY !== 1'b1) begin errors++; $display("FAIL timer_collapse got %b/%b want 100/1", PENDING, BUSY); end
    TIMER_EN = 1'b0;
    INT_IEND = 1'b1; step(1); INT_IEND = 1'b0;
    step(1);
    checks++; if (INT_IRQ !== 2'd3) begin errors++; $display("FAIL timer_repend got %0d want 3", INT_IRQ); end
    INT_IACK = 1'b1; step(1); INT_IACK = 1'b0;
    INT_IEND = 1'b1; step(1); INT_IEND = 1'b0;
    step(1);
    checks++; if (INT_IRQ !== 2'd0 || PENDING !== 3'b000) begin errors++; $display("FAIL timer_single got %0d/%b want 0/000", INT_IRQ, PENDING); end
  endtask

  task automatic test_proto;
    INT_IEND = 1'b1; step(1); INT_IEND = 1'b0;
    checks++; if (PROTO_ERR !== 1'b1 || BUSY !== 1'b0 || INT_IRQ !== 2'd0) begin errors++; $display("FAIL proto_iend_idle got %b/%b/%0d want 1/0/0", PROTO_ERR, BUSY, INT_IRQ); end
    ERR_CLR = 1'b1; step(1); ERR_CLR = 1'b0;
    checks++; if (PROTO_ERR !== 1'b0) begin errors++; $display("FAIL proto_clr got %b want 0", PROTO_ERR); end
    ERR_CLR = 1'b1; INT_IACK = 1'b1; step(1); ERR_CLR = 1'b0; INT_IACK = 1'b0;
    checks++; if (PROTO_ERR !== 1'b1 || BUSY !== 1'b0) begin errors++; $display("FAIL proto_err_wins got %b/%b want 1/0", PROTO_ERR, BUSY); end
    ERR_CLR = 1'b1; step(1); ERR_CLR = 1'b0;
    SRC_IN = 2'b01; step(1); SRC_IN = 2'b00; step(1);
    checks++; if (INT_IRQ !== 2'd1 || PROTO_ERR !== 1'b0) begin errors++; $display("FAIL proto_req got %0d/%b want 1/0", INT_IRQ, PROTO_ERR); end
    INT_IACK = 1'b1; INT_IEND = 1'b1; step(1); INT_IACK = 1'b0; INT_IEND = 1'b0;
    checks++; if (BUSY !== 1'b1 || INT_IRQ !== 2'd0 || PROTO_ERR !== 1'b1 || PENDING !== 3'b000) begin errors++; $display("FAIL proto_both got busy %b irq %0d err %b pend %b want 1 0 1 000", BUSY, INT_IRQ, PROTO_ERR, PENDING); end
    INT_IEND = 1'b1; step(1); INT_IEND = 1'b0;
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL proto_service_end got %b want 0", BUSY); end
    ERR_CLR = 1'b1; step(1); ERR_CLR = 1'b0;
  endtask

  task automatic test_reset_mid;
    SRC_IN = 2'b10; step(1); SRC_IN = 2'b00; step(1);
    INT_IACK = 1'b1; step(1); INT_IACK = 1'b0;
    SRC_IN = 2'b10; step(1); SRC_IN = 2'b00;
    INT_IACK = 1'b1; step(1); INT_IACK = 1'b0;
    checks++; if (BUSY !== 1'b1 || PENDING !== 3'b010 || PROTO_ERR !== 1'b1) begin errors++; $display("FAIL rmid_setup got %b/%b/%b want 1/010/1", BUSY, PENDING, PROTO_ERR); end
    RESET_N = 1'b0;
    #1;
    checks++; if (INT_IRQ !== 2'd0 || PENDING !== 3'b000 || BUSY !== 1'b0 || PROTO_ERR !== 1'b0) begin errors++; $display("FAIL rmid_async got %0d/%b/%b/%b want 0/000/0/0", INT_IRQ, PENDING, BUSY, PROTO_ERR); end
    step(2);
    RESET_N = 1'b1;
    step(3);
    checks++; if (INT_IRQ !== 2'd0 || PENDING !== 3'b000 || BUSY !== 1'b0) begin errors++; $display("FAIL rmid_quiet got %0d/%b/%b want 0/000/0", INT_IRQ, PENDING, BUSY); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_no_preempt();
    test_mask();
    test_timer();
    test_proto();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Responder end of the processor interrupt handshake (INT_IRQ / INT_IACK / INT_IEND).
- Latches rising-edge events from two external sources (keyboard, GPU) and one internal periodic timer.
- Selects the highest-priority enabled pending source and presents its code to the processor.
- Serializes service: one interrupt in flight, no preemption, closed by IEND.

Parameters:
- TIMER_PERIOD, 50000, timer tick period in CLK cycles; legal range 2..65535.

Ports:
- CLK  in  1  system clock, rising edge
- RESET_N  in  1  asynchronous active-low reset
- SRC_IN  in  2  raw external sources, synchronous to CLK; bit0 = keyboard, bit1 = GPU
- TIMER_EN  in  1  enables the periodic timer counter
- INT_MASK  in  3  per-source enable; bit2 = timer; 1 = eligible
- INT_IACK  in  1  processor acknowledge, one-cycle pulse
- INT_IEND  in  1  processor end-of-service, one-cycle pulse
- ERR_CLR  in  1  clears PROTO_ERR
- INT_IRQ  out  2  0 = none; 1/2/3 = source 0/1/2 requesting; registered
- PENDING  out  3  pending latch status
- BUSY  out  1  high whenever the FSM is not in IDLE
- PROTO_ERR  out  1  sticky handshake-violation flag

Behaviour:
- Reset (async, RESET_N low) clears the following immediately:
  - INT_IRQ=0, PENDING=0, BUSY=0, PROTO_ERR=0.
  - Edge registers = 0, timer count = 0, FSM = IDLE.
- Timer:
  - When TIMER_EN=1, count runs 0..TIMER_PERIOD-1 and wraps to 0.
  - tick = 1 for exactly one cycle when count = TIMER_PERIOD-1.
  - When TIMER_EN=0, count holds its value and tick = 0.
- Edge detect:
  - src_q is the previous-cycle sample of {tick, SRC_IN}.
  - edge = current & ~src_q.
  - A source already high when reset is released produces one edge.
- Pending latches:
  - pending <= (pending & ~clr) | edge.
  - If set and clear hit the same bit in the same cycle, set wins, so no event is lost.
  - Multiple edges on one source before service collapse into a single pending event.
- Priority: source 0 > source 1 > source 2. Eligible = pending & INT_MASK.
- A masked source stays pending and becomes eligible when it is unmasked.
- FSM, state IDLE:
  - INT_IRQ=0.
  - If eligible != 0: latch id = highest-priority eligible source, INT_IRQ <= id+1, go to REQUEST.
- FSM, state REQUEST:
  - INT_IRQ is held stable. Higher-priority arrivals and mask changes do not alter or withdraw it.
  - On IACK: clr[id]=1, INT_IRQ <= 0, go to SERVICE.
- FSM, state SERVICE:
  - INT_IRQ=0.
  - On IEND: go to IDLE.
- Latency:
  - SRC_IN rises before edge k → PENDING set after edge k → INT_IRQ valid after edge k+1.
  - IEND at edge n → back in IDLE; next INT_IRQ valid at the earliest after edge n+1.
- Protocol errors: PROTO_ERR <= 1 on either of:
  - IACK seen in IDLE or SERVICE;
  - IEND seen in IDLE or REQUEST, including IACK and IEND together in REQUEST.
  - In that simultaneous case IACK is still taken and the FSM moves to SERVICE.
  - An erroneous pulse never changes state or pending.
- ERR_CLR clears PROTO_ERR. A new error in the same cycle wins, so PROTO_ERR stays 1.

Decomposition:
- Shared package holds:
  - FSM state encodings IST_IDLE / IST_REQUEST / IST_SERVICE;
  - IRQ code constants IRQ_NONE=0, IRQ_KBD=1, IRQ_GPU=2, IRQ_TIMER=3;
  - source index constants.
- One sub-module, interrupt_timer: TIMER_PERIOD counter with enable, output tick.

Test Plan:
- Single source: SRC_IN[0] rises after reset with mask 3'b111:
  - INT_IRQ=1 two cycles after the rise.
  - IACK → INT_IRQ=0 and PENDING[0]=0.
  - IEND → BUSY=0.
- Simultaneous sources: SRC_IN=2'b11 in one cycle:
  - INT_IRQ=1 first.
  - After IACK and IEND, INT_IRQ=2.
  - After IACK and IEND, BUSY=0 and PENDING=0.
- No preemption and masking:
  - GPU in REQUEST, then keyboard rises → INT_IRQ stays 2 until IACK.
  - With mask bit0=0, the keyboard stays PENDING=001 and INT_IRQ=0 until the mask is set.
- Timer with TIMER_PERIOD=4 and TIMER_EN=1:
  - tick every 4 cycles; INT_IRQ=3 two cycles after the first tick.
  - Ticks arriving during service re-pend only one event.
- Protocol errors:
  - IEND in IDLE → PROTO_ERR=1, no state change.
  - ERR_CLR → PROTO_ERR=0.
  - IACK and IEND together in REQUEST → SERVICE entered and PROTO_ERR=1.
- Reset mid-service: RESET_N low while in SERVICE with PENDING=010 → all outputs 0 immediately; after release, no request unless a new edge arrives.
